// File: rtl/adder_sched_pkg.sv
// Shared types, defaults and the round-robin pick for the adder scheduler.
package adder_sched_pkg;

    localparam int unsigned DefaultDataW  = 4;
    localparam int unsigned DefaultAddLat = 1;
    localparam int unsigned MaxReq        = 8;
    localparam int unsigned MaxIdxW       = 3;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} sched_state_t;

    typedef struct packed {
        logic               found;
        logic [MaxIdxW-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping at num_req.
    function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0]  req,
                                         input logic [MaxIdxW-1:0] ptr,
                                         input int unsigned        num_req);
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            cand = (32'(ptr) + k) % num_req;
            if (k < num_req && !res.found && req[cand[MaxIdxW-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[MaxIdxW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_scheduler_rr_arbiter.sv
// Combinational round-robin pick; the pointer register lives in the caller.
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               found
);

    rr_pick_t pick;

    always_comb begin
        pick      = rr_pick(MaxReq'(req), MaxIdxW'(ptr), NUM_REQ);
        found     = pick.found;
        grant_idx = pick.idx[IDX_W-1:0];
        grant     = '0;
        if (pick.found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_scheduler.sv
// Shares one adder between NUM_REQ requesters: accept round-robin, issue, wait out
// the adder latency, then return the captured sum with a one-cycle pulse.
module adder_scheduler
    import adder_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DefaultDataW,
    parameter int unsigned ADD_LAT = DefaultAddLat
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W:0]            rsp_c,
    output logic [DATA_W-1:0]          add_a,
    output logic [DATA_W-1:0]          add_b,
    output logic                       add_valid,
    input  logic [DATA_W:0]            add_c,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    sched_state_t        state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     grant_id_q, grant_id_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;
    logic                add_valid_q, add_valid_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W:0]     rsp_c_q, rsp_c_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IdxW-1:0]     arb_idx;
    logic                arb_found;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .found     (arb_found)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        wait_cnt_d  = wait_cnt_q;
        add_valid_d = 1'b0;
        rsp_valid_d = '0;
        rsp_c_d     = rsp_c_q;
        req_ready   = '0;

        unique case (state_q)
            StIdle: begin
                // Ready is the arbiter winner, so a found winner is always a transfer.
                req_ready = arb_grant & {NUM_REQ{~reset}};
                if (arb_found) begin
                    op_a_d      = req_a[32'(arb_idx)*DATA_W +: DATA_W];
                    op_b_d      = req_b[32'(arb_idx)*DATA_W +: DATA_W];
                    grant_id_d  = arb_idx;
                    rr_ptr_d    = (arb_idx == IdxW'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
                    add_valid_d = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = CntW'(ADD_LAT-1);
                state_d    = StWait;
            end
            StWait: begin
                if (wait_cnt_q == '0) begin
                    rsp_c_d                 = add_c;
                    rsp_valid_d[grant_id_q] = 1'b1;
                    state_d                 = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            wait_cnt_q  <= '0;
            add_valid_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_c_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            wait_cnt_q  <= wait_cnt_d;
            add_valid_q <= add_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_c_q     <= rsp_c_d;
            busy_q      <= busy_d;
        end
    end

    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign add_valid = add_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Round-robin scheduler that shares a single `adder` instance between `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one requester at a time, drives the adder's `a`/`b`/`valid` inputs, waits out the adder latency, captures `c`, and returns it to the granted requester with a one-cycle response pulse. It sits between the requesting units and the `adder` DUT, driving that DUT's ports directly.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 4: adder operand width.
- `ADD_LAT`, 1: adder latency in cycles from the `valid` cycle to `c` being stable, 1..4.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  NUM_REQ: per-requester operand valid.
- `req_ready`  out  NUM_REQ: per-requester accept, at most one bit set.
- `req_a`  in  NUM_REQ*DATA_W: operand A; requester i uses bits [i*DATA_W +: DATA_W].
- `req_b`  in  NUM_REQ*DATA_W: operand B, same packing as `req_a`.
- `rsp_valid`  out  NUM_REQ: one-cycle result pulse to the owning requester.
- `rsp_c`  out  DATA_W+1: result, shared by all requesters, qualified by `rsp_valid`.
- `add_a`  out  DATA_W: to adder `a`.
- `add_b`  out  DATA_W: to adder `b`.
- `add_valid`  out  1: to adder `valid`.
- `add_c`  in  DATA_W+1: from adder `c`.
- `busy`  out  1: high in any state other than IDLE.
- `grant_id`  out  $clog2(NUM_REQ): id of the current or last granted requester.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE:**
  - `req_ready` = one-hot of the winning `req_valid` bit, searched round-robin starting at `rr_ptr`.
  - This is combinational and is 0 when no requester is valid.
  - A transfer happens when `req_valid[i] & req_ready[i]`. On a transfer: latch operands into `op_a`/`op_b`, set `grant_id=i`, set `rr_ptr=(i+1) mod NUM_REQ`, go to ISSUE.
- **ISSUE:**
  - Drive `add_valid=1`, `add_a=op_a`, `add_b=op_b` for exactly one cycle.
  - Load `wait_cnt=ADD_LAT-1`, go to WAIT.
- **WAIT:**
  - `add_valid=0`; `add_a`/`add_b` hold their values.
  - Decrement `wait_cnt`.
  - When `wait_cnt==0`, register `add_c` into `rsp_c` and go to RESP.
- **RESP:**
  - `rsp_valid[grant_id]=1` for one cycle, then go to IDLE.
  - `rsp_c` holds its value until the next capture.
- `req_ready` is 0 in every state other than IDLE, so only one operation is outstanding at a time.
- There is no truncation: `rsp_c` is DATA_W+1 bits and carries the adder carry-out unmodified.
- A requester holding `req_valid` through its own response is served again only after its turn comes around in round-robin order.

## Timing
- Reset values: state=IDLE, `rr_ptr=0`, `grant_id=0`, `add_a=0`, `add_b=0`, `add_valid=0`, `rsp_valid=0`, `rsp_c=0`, `busy=0`. `req_ready` is 0 while `reset` is high.
- With the handshake in cycle T:
  - ISSUE in T+1.
  - WAIT in T+2 .. T+1+ADD_LAT.
  - `rsp_valid` in T+2+ADD_LAT.
  - The next accept is possible in T+3+ADD_LAT.
- Throughput is one operation per ADD_LAT+3 cycles.
- Requests arriving simultaneously: the first set bit at or after `rr_ptr` wins. The pointer wraps from NUM_REQ-1 to 0.
- `req_valid` deasserted while not granted: legal, no effect.
- Reset mid-operation: return to IDLE immediately. No `rsp_valid` is issued, `add_valid` drops asynchronously, and the pending operation is discarded.
- All outputs except `req_ready` are registered.

## Structure
- Package `adder_sched_pkg`:
  - enum `sched_state_t` with {IDLE, ISSUE, WAIT, RESP};
  - `localparam` defaults for DATA_W and ADD_LAT;
  - function `rr_pick(req, ptr)` returning the winner index and a found flag.
- Sub-module `rr_arbiter`: combinational round-robin pick over NUM_REQ; the pointer register stays in `adder_scheduler`.
- Top-level bench: `adder_scheduler` instanced alongside `adder`, with `add_*` wired to the adder ports on the same `clk`/`reset`.

## Test plan
- **Single request, ADD_LAT=1:** req 2 with a=4'h3, b=4'h5 at cycle 10 → `add_valid` in cycle 11, `rsp_valid[2]` in cycle 13, `rsp_c`=5'h08.
- **Carry-out:** req 0 with a=4'hF, b=4'hF → `rsp_c`=5'h1E and only `rsp_valid[0]` pulses.
- **Simultaneous requests:** all four requesters assert in the same cycle from reset and hold → grants in order 0,1,2,3,0, spaced 4 cycles apart; each `rsp_c` matches its own operands.
- **Pointer wrap:** after granting 3, requesters 1 and 3 both valid → 1 is granted and `rr_ptr` becomes 2.
- **Reset mid-operation:** assert `reset` during WAIT → no `rsp_valid`; after release, all outputs are at reset values and the next request is served normally.
- **ADD_LAT=3 build:** a=4'h7, b=4'h9 → `rsp_valid` at T+5, `rsp_c`=5'h10; `add_valid` is high for exactly one cycle.
